// File: rtl/emtf_axil_reg_slave.sv
// emtf_axil_reg_slave: AXI4-Lite slave with NUM_REGS read/write control registers.
// Contents go to EMTF fabric as a flat bus plus one-cycle per-register write pulses.
module emtf_axil_reg_slave #(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 5,
    parameter int                            NUM_REGS           = 4,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE        = 32'h0
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [NUM_REGS*32-1:0]          reg_out,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e                   w_state_q, w_state_d;
    r_state_e                   r_state_q, r_state_d;
    logic                       aw_done_q, aw_done_d;
    logic                       w_done_q, w_done_d;
    logic [IDX_W-1:0]           aw_idx_q, aw_idx_d;
    logic [DW-1:0]              wdata_q, wdata_d;
    logic [SW-1:0]              wstrb_q, wstrb_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]        pulse_q, pulse_d;
    logic [DW-1:0]              rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;

    logic             aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0] ar_idx;
    logic             unused_bits;

    assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
    assign w_hs   = s00_axi_wvalid & s00_axi_wready;
    assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
    assign ar_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= OKAY;
            regs_q    <= {NUM_REGS{RESET_VALUE}};
            pulse_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            regs_q    <= regs_d;
            pulse_q   <= pulse_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // AW and W latch independently; commit once both are held
    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        pulse_d   = '0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    aw_idx_d  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wdata_d  = s00_axi_wdata;
                    wstrb_d  = s00_axi_wstrb;
                end
                if (aw_done_q && w_done_q) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_RESP;
                    bresp_d   = SLVERR;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (int'(aw_idx_q) == k) begin
                            bresp_d    = OKAY;
                            pulse_d[k] = 1'b1;
                            for (int j = 0; j < SW; j++) begin
                                if (wstrb_q[j])
                                    regs_d[k][8*j +: 8] = wdata_q[8*j +: 8];
                            end
                        end
                    end
                end
            end
            W_RESP: if (s00_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Reads sample regs_q, so a same-edge write commit is not yet visible
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: if (ar_hs) begin
                r_state_d = R_DATA;
                rdata_d   = '0;
                rresp_d   = SLVERR;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (int'(ar_idx) == k) begin
                        rdata_d = regs_q[k];
                        rresp_d = OKAY;
                    end
                end
            end
            R_DATA: if (s00_axi_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s00_axi_awready = !s00_axi_areset && (w_state_q == W_IDLE) && !aw_done_q;
        s00_axi_wready  = !s00_axi_areset && (w_state_q == W_IDLE) && !w_done_q;
        s00_axi_bvalid  = !s00_axi_areset && (w_state_q == W_RESP);
        s00_axi_arready = !s00_axi_areset && (r_state_q == R_IDLE);
        s00_axi_rvalid  = !s00_axi_areset && (r_state_q == R_DATA);
        s00_axi_bresp   = bresp_q;
        s00_axi_rdata   = rdata_q;
        s00_axi_rresp   = rresp_q;
        reg_out         = regs_q;
        reg_wr_pulse    = pulse_q;
    end
endmodule

// File: tb/tb_emtf_axil_reg_slave.sv
// tb_emtf_axil_reg_slave: directed and randomized AXI4-Lite traffic
// checked against an array-based register model.
module tb_emtf_axil_reg_slave;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0]     awaddr, araddr;
    logic           awvalid, awready, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rvalid, rready;
    logic [31:0]    wdata, rdata;
    logic [3:0]     wstrb;
    logic [1:0]     bresp, rresp;
    logic [NR*32-1:0] reg_out;
    logic [NR-1:0]  reg_wr_pulse;

    emtf_axil_reg_slave #(.NUM_REGS(NR)) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000),
        .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [31:0] model [NR];
    int exp_pulses [NR] = '{default: 0};
    int got_pulses [NR] = '{default: 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst)
            for (int k = 0; k < NR; k++)
                if (reg_wr_pulse[k]) got_pulses[k]++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*32-1:0] model_bus();
        logic [NR*32-1:0] b;
        for (int k = 0; k < NR; k++) b[32*k +: 32] = model[k];
        return b;
    endfunction

    function automatic bit in_range(input logic [4:0] a);
        return int'(a[4:2]) < NR;
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        int i = int'(a[4:2]);
        logic [31:0] m;
        if (i >= NR) return;
        for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{s[j]}};
        model[i] = (model[i] & ~m) | (d & m);
        exp_pulses[i]++;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [4:0] a, output int hc);
        int n = 0;
        logic r;
        awaddr = a; awvalid = 1'b1;
        forever begin
            r = awready;
            tick();
            if (r) break;
            n++;
            if (n > 50) begin check("aw_timeout", 0, 1); break; end
        end
        hc = cyc; awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hc);
        int n = 0;
        logic r;
        wdata = d; wstrb = s; wvalid = 1'b1;
        forever begin
            r = wready;
            tick();
            if (r) break;
            n++;
            if (n > 50) begin check("w_timeout", 0, 1); break; end
        end
        hc = cyc; wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [4:0] a);
        int n = 0;
        logic r;
        araddr = a; arvalid = 1'b1;
        forever begin
            r = arready;
            tick();
            if (r) break;
            n++;
            if (n > 50) begin check("ar_timeout", 0, 1); break; end
        end
        arvalid = 1'b0;
    endtask

    task automatic wait_b(input logic [4:0] a, input int later, input int stall);
        int n = 0;
        logic [1:0] er;
        logic [NR-1:0] ep;
        er = in_range(a) ? 2'b00 : 2'b10;
        ep = in_range(a) ? (NR'(1) << a[4:2]) : '0;
        while (!bvalid && n < 50) begin tick(); n++; end
        check("bvalid_seen", bvalid, 1);
        check("b_latency", cyc, later + 1);
        check("bresp", bresp, er);
        check("wr_pulse", reg_wr_pulse, ep);
        check("reg_out", reg_out, model_bus());
        repeat (stall) begin
            tick();
            check("b_hold", {bvalid, bresp, awready, wready}, {1'b1, er, 2'b00});
            check("pulse_once", reg_wr_pulse, 0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_done", {bvalid, reg_wr_pulse}, 0);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int daw, input int dw, input int stall);
        int ca, cw;
        fork
            begin repeat (daw) tick(); send_aw(a, ca); end
            begin repeat (dw) tick(); send_w(d, s, cw); end
        join
        model_write(a, d, s);
        wait_b(a, (ca > cw) ? ca : cw, stall);
    endtask

    task automatic do_read(input logic [4:0] a, input int stall);
        int n = 0;
        logic [31:0] ed;
        logic [1:0] er;
        ed = in_range(a) ? model[a[4:2]] : 32'h0;
        er = in_range(a) ? 2'b00 : 2'b10;
        send_ar(a);
        while (!rvalid && n < 50) begin tick(); n++; end
        check("rvalid_seen", rvalid, 1);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        repeat (stall) begin
            tick();
            check("r_hold", {rvalid, rdata, rresp, arready}, {1'b1, ed, er, 1'b0});
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("r_done", rvalid, 0);
    endtask

    initial begin
        int ca, cw;
        rst = 1'b1;
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        model_reset();
        repeat (3) tick();
        check("rst_handshake", {awready, wready, arready, bvalid, rvalid}, 0);
        check("rst_outputs", {bresp, rresp, rdata, reg_wr_pulse}, 0);
        check("rst_reg_out", reg_out, 0);
        rst = 1'b0;
        tick();
        check("idle_ready", {awready, wready, arready}, 3'b111);

        // basic write/readback
        for (int k = 0; k < NR; k++) do_write(5'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
        for (int k = 0; k < NR; k++) do_read(5'(4 * k), 0);
        check("t1_reg_out", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});

        // byte strobes
        do_write(5'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        do_write(5'h00, 32'h11223344, 4'b0101, 0, 0, 0);
        check("t2_reg0", reg_out[31:0], 32'hAA22CC44);
        do_read(5'h00, 0);

        // AW three cycles before W, then W before AW
        send_aw(5'h08, ca);
        check("aw_captured", {awready, wready}, 2'b01);
        repeat (3) tick();
        check("aw_still_low", {awready, wready}, 2'b01);
        send_w(32'hCAFEF00D, 4'hF, cw);
        model_write(5'h08, 32'hCAFEF00D, 4'hF);
        wait_b(5'h08, cw, 0);
        send_w(32'h0BADBEEF, 4'hF, cw);
        check("w_captured", {awready, wready}, 2'b10);
        repeat (2) tick();
        send_aw(5'h0C, ca);
        model_write(5'h0C, 32'h0BADBEEF, 4'hF);
        wait_b(5'h0C, ca, 0);

        // back-pressure on B and R
        do_write(5'h04, 32'h12345678, 4'hF, 0, 0, 5);
        do_read(5'h04, 5);

        // out-of-range accesses
        do_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_read(5'h1C, 0);
        do_write(5'h00, 32'h0, 4'h0, 1, 0, 1);

        // independent channels concurrently
        fork
            do_write(5'h04, 32'h600DCAFE, 4'hF, 1, 2, 2);
            do_read(5'h08, 3);
        join

        for (int it = 0; it < 80; it++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end

        // reset with a captured AW still waiting for W
        send_aw(5'h04, ca);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        repeat (5) begin
            check("no_b_after_reset", bvalid, 0);
            tick();
        end
        check("reset_reg_out", reg_out, 0);
        check("reset_ready", {awready, wready}, 2'b11);
        do_write(5'h04, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
        do_read(5'h04, 0);

        tick();
        for (int k = 0; k < NR; k++) check("pulse_count", got_pulses[k], exp_pulses[k]);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
